// File: rtl/axicb_harq_arbiter.sv
// axicb_harq_arbiter
// Round-robin arbiter for one shared crossbar master port. After each accepted
// transfer it waits for the ECC verdict and, on error or timeout, re-grants the
// same requester for a retransmission until the retry budget is spent.
module axicb_harq_arbiter #(
    parameter int MST_NB      = 4,
    parameter int MAX_RETRY   = 3,
    parameter int ECC_TIMEOUT = 64
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [MST_NB-1:0]              req,
    input  logic                           xfer_hs,
    input  logic                           ecc_valid,
    input  logic                           ecc_err,
    output logic [MST_NB-1:0]              grant,
    output logic [$clog2(MST_NB)-1:0]      grant_id,
    output logic                           retx,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic                           done,
    output logic                           fail,
    output logic                           busy
);

    localparam int ID_W  = $clog2(MST_NB);
    localparam int ID_W1 = ID_W + 1;
    localparam int RC_W  = $clog2(MAX_RETRY + 1);
    localparam int TO_W  = $clog2(ECC_TIMEOUT);

    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(MST_NB - 1);
    localparam logic [ID_W:0]    NB_EXT    = ID_W1'(MST_NB);
    localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRY);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ECC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_ECC
    } state_t;

    // Registered state
    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [MST_NB-1:0] r_grant;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_retx;
    logic [RC_W-1:0]   r_retry_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_done;
    logic              r_fail;

    // Next-state values
    state_t            w_state_nxt;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [MST_NB-1:0] w_grant_nxt;
    logic [ID_W-1:0]   w_grant_id_nxt;
    logic              w_retx_nxt;
    logic [RC_W-1:0]   w_retry_nxt;
    logic [TO_W-1:0]   w_to_cnt_nxt;
    logic              w_done_nxt;
    logic              w_fail_nxt;

    // Arbitration and helper terms
    logic [MST_NB-1:0] w_req_rot;
    logic              w_arb_found;
    logic [ID_W-1:0]   w_arb_off;
    logic [ID_W:0]     w_arb_sum;
    logic [ID_W-1:0]   w_arb_idx;
    logic [ID_W-1:0]   w_ptr_after;
    logic [MST_NB-1:0] w_grant_same;
    logic [MST_NB-1:0] w_grant_new;
    logic              w_ecc_bad;
    logic              w_ecc_clean;

    // Rotate the requests so bit 0 is the requester sitting at the priority pointer.
    assign w_req_rot = MST_NB'({req, req} >> r_ptr);

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_off   = '0;
        for (int i = MST_NB - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_arb_found = 1'b1;
                w_arb_off   = ID_W'(i);
            end
        end
    end

    // Winner index wraps with a compare so non-power-of-2 requester counts work.
    assign w_arb_sum = {1'b0, r_ptr} + {1'b0, w_arb_off};
    assign w_arb_idx = (w_arb_sum >= NB_EXT) ? ID_W'(w_arb_sum - NB_EXT) : ID_W'(w_arb_sum);

    // Priority moves to the requester after the one that just finished.
    assign w_ptr_after  = (r_grant_id == LAST_ID) ? '0 : r_grant_id + ID_W'(1);
    assign w_grant_same = MST_NB'(1) << r_grant_id;
    assign w_grant_new  = MST_NB'(1) << w_arb_idx;

    // A verdict in the timeout cycle overrides the timeout itself.
    assign w_ecc_clean = ecc_valid & ~ecc_err;
    assign w_ecc_bad   = ecc_valid ? ecc_err : (r_to_cnt == TO_LAST);

    // Next-state and output decode for the arbitration / retransmission sequencer.
    always_comb begin
        // NOTE: every next value is given its hold default before the case, so no
        // path leaves it unassigned and no latch is inferred.
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_retx_nxt     = r_retx;
        w_retry_nxt    = r_retry_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_done_nxt     = 1'b0;
        w_fail_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_retx_nxt = 1'b0;
                if (w_arb_found) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_nxt    = w_grant_new;
                    w_grant_id_nxt = w_arb_idx;
                    w_retry_nxt    = '0;
                end
            end

            S_GRANT: begin
                if (xfer_hs) begin
                    w_state_nxt  = S_WAIT_ECC;
                    w_grant_nxt  = '0;
                    w_to_cnt_nxt = '0;
                end else if (!req[r_grant_id]) begin
                    // Requester withdrew before its transfer: silent abort.
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_ptr_after;
                    w_retx_nxt  = 1'b0;
                end
            end

            S_WAIT_ECC: begin
                w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                if (w_ecc_clean) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_ptr_nxt   = w_ptr_after;
                    w_retx_nxt  = 1'b0;
                end else if (w_ecc_bad) begin
                    if (r_retry_cnt < RETRY_MAX) begin
                        // Retransmit to the same requester without re-arbitrating.
                        w_state_nxt = S_GRANT;
                        w_grant_nxt = w_grant_same;
                        w_retry_nxt = r_retry_cnt + RC_W'(1);
                        w_retx_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_fail_nxt  = 1'b1;
                        w_ptr_nxt   = w_ptr_after;
                        w_retx_nxt  = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_retx_nxt  = 1'b0;
            end
        endcase
    end

    // State register; reset drops grant and all status at once.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_grant_id  <= '0;
            r_retx      <= 1'b0;
            r_retry_cnt <= '0;
            r_to_cnt    <= '0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_retx      <= w_retx_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_done      <= w_done_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    assign grant     = r_grant;
    assign grant_id  = r_grant_id;
    assign retx      = r_retx;
    assign retry_cnt = r_retry_cnt;
    assign done      = r_done;
    assign fail      = r_fail;
    assign busy      = (r_state != S_IDLE);

endmodule
